// File: rtl/monopix_readout_emu.sv
// MONOPIX column-drain readout emulator: hit FIFO, FREEZE/READ handshake, serial DATA.
// Optional test-pattern source is compiled in with `define MONOPIX_EMU_TEST_PATTERN_EN.
`timescale 1ns/1ps

module monopix_readout_emu #(
    parameter int                    DATA_WIDTH = 26,
    parameter int                    DEPTH      = 16,
    parameter logic [DATA_WIDTH-1:0] PATTERN    = 26'h2AAAAAA
) (
    input  logic                  CLK40,
    input  logic                  nRST,
    input  logic                  HIT_WR,
    input  logic [DATA_WIDTH-1:0] HIT_DATA,
    output logic                  HIT_FULL,
    input  logic                  FREEZE,
    input  logic                  READ,
    input  logic                  EN_TEST_PATTERN,
    output logic                  TOKEN,
    output logic                  DATA,
    output logic                  BUSY,
    output logic [7:0]            LOST_CNT,
    output logic                  READ_ERR
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);
    localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         frz_cnt;
    logic                  read_d;
    logic                  freeze_d;
    logic                  load_pattern;
    state_t                state;
    logic [DATA_WIDTH-1:0] sr;
    logic [BW-1:0]         bit_cnt;

    logic                  read_edge;
    logic                  freeze_rise;
    logic                  full;
    logic [CW-1:0]         frz_view;
    logic                  word_avail;
    logic                  pattern_mode;
    logic                  eligible;
    logic                  pop;
    logic                  push;
    logic                  drop;
    logic [DATA_WIDTH-1:0] load_word;

`ifdef MONOPIX_EMU_TEST_PATTERN_EN
    assign pattern_mode = EN_TEST_PATTERN;
`else
    logic unused_en_test_pattern;
    assign unused_en_test_pattern = EN_TEST_PATTERN;
    assign pattern_mode = 1'b0;
`endif

    assign read_edge   = READ & ~read_d;
    assign freeze_rise = FREEZE & ~freeze_d;
    assign full        = (count == FULL_LEVEL);
    // On the freeze edge itself FRZ_CNT is not loaded yet, so the live count stands in.
    assign frz_view    = freeze_rise ? count : frz_cnt;
    assign word_avail  = FREEZE ? (frz_view != '0) : (count != '0);
    assign eligible    = pattern_mode | word_avail;
    assign pop         = (state == LOAD) && !load_pattern && (count != '0);
    assign push        = HIT_WR && (!full || pop);
    assign drop        = HIT_WR && full && !pop;
    assign load_word   = load_pattern ? PATTERN : mem[rd_ptr];

    always_ff @(posedge CLK40) begin
        if (push) begin
            mem[wr_ptr] <= HIT_DATA;
        end
    end

    always_ff @(posedge CLK40 or negedge nRST) begin
        if (!nRST) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            frz_cnt      <= '0;
            read_d       <= 1'b0;
            freeze_d     <= 1'b0;
            load_pattern <= 1'b0;
            state        <= IDLE;
            sr           <= '0;
            bit_cnt      <= '0;
            HIT_FULL     <= 1'b0;
            TOKEN        <= 1'b0;
            DATA         <= 1'b0;
            BUSY         <= 1'b0;
            LOST_CNT     <= 8'd0;
            READ_ERR     <= 1'b0;
        end else begin
            read_d   <= READ;
            freeze_d <= FREEZE;

            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);

            if (freeze_rise) begin
                frz_cnt <= count - CW'(pop);
            end else if (FREEZE && pop && (frz_cnt != '0)) begin
                frz_cnt <= frz_cnt - CW'(1);
            end

            if (drop && (LOST_CNT != 8'hFF)) begin
                LOST_CNT <= LOST_CNT + 8'd1;
            end

            HIT_FULL <= full;
            TOKEN    <= eligible;

            if (read_edge && ((state != IDLE) || !eligible)) begin
                READ_ERR <= 1'b1;
            end

            case (state)
                IDLE: begin
                    DATA <= 1'b0;
                    if (read_edge && eligible) begin
                        load_pattern <= pattern_mode;
                        state        <= LOAD;
                    end
                end
                LOAD: begin
                    // MSB goes out with the load so it appears one cycle after LOAD.
                    DATA    <= load_word[DATA_WIDTH-1];
                    sr      <= load_word << 1;
                    bit_cnt <= LAST_BIT;
                    BUSY    <= 1'b1;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    if (bit_cnt == '0) begin
                        DATA  <= 1'b0;
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        DATA    <= sr[DATA_WIDTH-1];
                        sr      <= sr << 1;
                        bit_cnt <= bit_cnt - BW'(1);
                    end
                end
                default: begin
                    DATA  <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_monopix_readout_emu.sv
// Self-checking bench for monopix_readout_emu: queue model of the hit FIFO plus a
// scoreboard of expected serial words, one task per scenario.
`timescale 1ns/1ps

module tb_monopix_readout_emu;

    localparam int DW    = 26;
    localparam int DEPTH = 16;
    localparam logic [DW-1:0] PATTERN = 26'h2AAAAAA;

    logic          CLK40 = 1'b0;
    logic          nRST = 1'b0;
    logic          HIT_WR = 1'b0;
    logic [DW-1:0] HIT_DATA = '0;
    logic          FREEZE = 1'b0;
    logic          READ = 1'b0;
    logic          EN_TEST_PATTERN = 1'b0;
    logic          HIT_FULL;
    logic          TOKEN;
    logic          DATA;
    logic          BUSY;
    logic [7:0]    LOST_CNT;
    logic          READ_ERR;

    int errors = 0;
    int checks = 0;
    int model_lost = 0;
    logic [DW-1:0] model_q [$];
    logic [DW-1:0] exp_q [$];

    monopix_readout_emu #(
        .DATA_WIDTH(DW),
        .DEPTH(DEPTH),
        .PATTERN(PATTERN)
    ) dut (
        .CLK40(CLK40),
        .nRST(nRST),
        .HIT_WR(HIT_WR),
        .HIT_DATA(HIT_DATA),
        .HIT_FULL(HIT_FULL),
        .FREEZE(FREEZE),
        .READ(READ),
        .EN_TEST_PATTERN(EN_TEST_PATTERN),
        .TOKEN(TOKEN),
        .DATA(DATA),
        .BUSY(BUSY),
        .LOST_CNT(LOST_CNT),
        .READ_ERR(READ_ERR)
    );

    always #12.5 CLK40 = ~CLK40;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        nRST = 1'b0;
        HIT_WR = 1'b0;
        READ = 1'b0;
        FREEZE = 1'b0;
        EN_TEST_PATTERN = 1'b0;
        model_q.delete();
        exp_q.delete();
        model_lost = 0;
        repeat (2) @(negedge CLK40);
        nRST = 1'b1;
        @(negedge CLK40);
    endtask

    // Called just after a negedge; returns at the next negedge.
    task automatic write_word(input logic [DW-1:0] d);
        HIT_WR = 1'b1;
        HIT_DATA = d;
        if (model_q.size() < DEPTH) model_q.push_back(d);
        else if (model_lost < 255) model_lost++;
        @(negedge CLK40);
        HIT_WR = 1'b0;
    endtask

    // Issues one READ edge and captures the serial word; optional extra READ edge
    // while bit err_at is on DATA, optional write during the LOAD cycle.
    task automatic read_word(input string name, input int err_at, input bit wr_in_load,
                             input logic [DW-1:0] wr_d, input bit use_pattern);
        logic [DW-1:0] got;
        logic [DW-1:0] exp;
        got = '0;
        READ = 1'b1;
        if (use_pattern) exp_q.push_back(PATTERN);
        else exp_q.push_back(model_q.pop_front());
        @(negedge CLK40);
        READ = 1'b0;
        checks++;
        if (DATA !== 1'b0) begin
            errors++;
            $display("FAIL %s_load_data: got %b expected 0", name, DATA);
        end
        if (wr_in_load) begin
            HIT_WR = 1'b1;
            HIT_DATA = wr_d;
            model_q.push_back(wr_d);
        end
        for (int i = DW - 1; i >= 0; i--) begin
            @(negedge CLK40);
            HIT_WR = 1'b0;
            got[i] = DATA;
            checks++;
            if (BUSY !== 1'b1) begin
                errors++;
                $display("FAIL %s_busy_bit%0d: got %b expected 1", name, i, BUSY);
            end
            READ = (i == err_at);
        end
        @(negedge CLK40);
        READ = 1'b0;
        checks++;
        if (BUSY !== 1'b0 || DATA !== 1'b0) begin
            errors++;
            $display("FAIL %s_end: got busy=%b data=%b expected busy=0 data=0", name, BUSY, DATA);
        end
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s_word: got %h expected %h", name, got, exp);
        end
        $display("read %s: word %h expected %h", name, got, exp);
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        repeat (3) @(negedge CLK40);
        checks++;
        if ({TOKEN, DATA, BUSY, HIT_FULL, READ_ERR} !== 5'b0 || LOST_CNT !== 8'd0) begin
            errors++;
            $display("FAIL reset_in: got tok=%b data=%b busy=%b full=%b err=%b lost=%h expected all 0",
                     TOKEN, DATA, BUSY, HIT_FULL, READ_ERR, LOST_CNT);
        end
        nRST = 1'b1;
        repeat (2) @(negedge CLK40);
        checks++;
        if ({TOKEN, DATA, BUSY, HIT_FULL, READ_ERR} !== 5'b0 || LOST_CNT !== 8'd0) begin
            errors++;
            $display("FAIL reset_after: got tok=%b data=%b busy=%b full=%b err=%b lost=%h expected all 0",
                     TOKEN, DATA, BUSY, HIT_FULL, READ_ERR, LOST_CNT);
        end
        $display("reset: outputs checked");
    endtask

    task automatic test_single_word();
        do_reset();
        write_word(26'h1234567);
        @(negedge CLK40);
        checks++;
        if (TOKEN !== 1'b1) begin
            errors++;
            $display("FAIL single_token_rise: got %b expected 1", TOKEN);
        end
        read_word("single", -1, 1'b0, '0, 1'b0);
        checks++;
        if (TOKEN !== 1'b0 || READ_ERR !== 1'b0 || LOST_CNT !== 8'd0) begin
            errors++;
            $display("FAIL single_after: got tok=%b err=%b lost=%h expected 0 0 00", TOKEN, READ_ERR, LOST_CNT);
        end
    endtask

    task automatic test_freeze();
        do_reset();
        for (int i = 0; i < 3; i++) write_word(DW'(26'h0100000 + i));
        @(negedge CLK40);
        FREEZE = 1'b1;
        @(negedge CLK40);
        for (int i = 3; i < 5; i++) write_word(DW'(26'h0100000 + i));
        @(negedge CLK40);
        checks++;
        if (TOKEN !== 1'b1) begin
            errors++;
            $display("FAIL freeze_token_hi: got %b expected 1", TOKEN);
        end
        for (int i = 0; i < 3; i++) read_word("frozen", -1, 1'b0, '0, 1'b0);
        checks++;
        if (TOKEN !== 1'b0) begin
            errors++;
            $display("FAIL freeze_token_drop: got %b expected 0", TOKEN);
        end
        READ = 1'b1;
        @(negedge CLK40);
        READ = 1'b0;
        @(negedge CLK40);
        checks++;
        if (READ_ERR !== 1'b1 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL freeze_read_ineligible: got err=%b busy=%b expected 1 0", READ_ERR, BUSY);
        end
        FREEZE = 1'b0;
        repeat (2) @(negedge CLK40);
        checks++;
        if (TOKEN !== 1'b1) begin
            errors++;
            $display("FAIL unfreeze_token: got %b expected 1", TOKEN);
        end
        for (int i = 0; i < 2; i++) read_word("unfrozen", -1, 1'b0, '0, 1'b0);
        checks++;
        if (TOKEN !== 1'b0) begin
            errors++;
            $display("FAIL unfreeze_drained: got %b expected 0", TOKEN);
        end
    endtask

    task automatic test_full_lost();
        do_reset();
        for (int i = 0; i < DEPTH + 3; i++) write_word(DW'($urandom));
        repeat (2) @(negedge CLK40);
        checks++;
        if (HIT_FULL !== 1'b1 || LOST_CNT !== 8'(model_lost)) begin
            errors++;
            $display("FAIL full_lost3: got full=%b lost=%0d expected 1 %0d", HIT_FULL, LOST_CNT, model_lost);
        end
        for (int i = 0; i < 300; i++) write_word(DW'($urandom));
        @(negedge CLK40);
        checks++;
        if (LOST_CNT !== 8'hFF) begin
            errors++;
            $display("FAIL lost_saturate: got %h expected ff", LOST_CNT);
        end
        read_word("full_wr_pop", -1, 1'b1, 26'h3C0FFEE, 1'b0);
        checks++;
        if (HIT_FULL !== 1'b1) begin
            errors++;
            $display("FAIL full_after_wr_pop: got %b expected 1", HIT_FULL);
        end
        for (int i = 0; i < DEPTH; i++) read_word("drain", -1, 1'b0, '0, 1'b0);
        checks++;
        if (HIT_FULL !== 1'b0 || TOKEN !== 1'b0) begin
            errors++;
            $display("FAIL drained: got full=%b tok=%b expected 0 0", HIT_FULL, TOKEN);
        end
    endtask

    task automatic test_read_err();
        do_reset();
        checks++;
        if (READ_ERR !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: got %b expected 0", READ_ERR);
        end
        READ = 1'b1;
        @(negedge CLK40);
        READ = 1'b0;
        @(negedge CLK40);
        checks++;
        if (READ_ERR !== 1'b1 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL err_empty: got err=%b busy=%b expected 1 0", READ_ERR, BUSY);
        end
        do_reset();
        write_word(26'h2F0F0F1);
        @(negedge CLK40);
        read_word("mid_shift_edge", 10, 1'b0, '0, 1'b0);
        checks++;
        if (READ_ERR !== 1'b1) begin
            errors++;
            $display("FAIL err_mid_shift: got %b expected 1", READ_ERR);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK40);
            checks++;
            if (DATA !== 1'b0 || BUSY !== 1'b0) begin
                errors++;
                $display("FAIL err_idle_data: got data=%b busy=%b expected 0 0", DATA, BUSY);
            end
        end
    endtask

    task automatic test_reset_mid_shift();
        do_reset();
        write_word(26'h3FFFFFF);
        write_word(26'h1555555);
        @(negedge CLK40);
        READ = 1'b1;
        @(negedge CLK40);
        READ = 1'b0;
        repeat (DW - 10) @(negedge CLK40);
        checks++;
        if (BUSY !== 1'b1 || TOKEN !== 1'b1 || DATA !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_shift: got busy=%b tok=%b data=%b expected 1 1 1", BUSY, TOKEN, DATA);
        end
        #3 nRST = 1'b0;
        #1;
        checks++;
        if (DATA !== 1'b0 || BUSY !== 1'b0 || TOKEN !== 1'b0 || HIT_FULL !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got data=%b busy=%b tok=%b full=%b expected 0 0 0 0",
                     DATA, BUSY, TOKEN, HIT_FULL);
        end
        @(negedge CLK40);
        nRST = 1'b1;
        model_q.delete();
        exp_q.delete();
        @(negedge CLK40);
        checks++;
        if (TOKEN !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_empty: got tok=%b busy=%b expected 0 0", TOKEN, BUSY);
        end
        write_word(26'h0ABCDEF);
        @(negedge CLK40);
        read_word("after_reset", -1, 1'b0, '0, 1'b0);
    endtask

    task automatic test_pattern();
        do_reset();
        EN_TEST_PATTERN = 1'b1;
        repeat (2) @(negedge CLK40);
`ifdef MONOPIX_EMU_TEST_PATTERN_EN
        checks++;
        if (TOKEN !== 1'b1) begin
            errors++;
            $display("FAIL pattern_token: got %b expected 1", TOKEN);
        end
        read_word("pattern", -1, 1'b0, '0, 1'b1);
        EN_TEST_PATTERN = 1'b0;
        repeat (2) @(negedge CLK40);
        checks++;
        if (TOKEN !== 1'b0 || READ_ERR !== 1'b0) begin
            errors++;
            $display("FAIL pattern_fifo_untouched: got tok=%b err=%b expected 0 0", TOKEN, READ_ERR);
        end
`else
        checks++;
        if (TOKEN !== 1'b0) begin
            errors++;
            $display("FAIL nopattern_token: got %b expected 0", TOKEN);
        end
        READ = 1'b1;
        @(negedge CLK40);
        READ = 1'b0;
        @(negedge CLK40);
        checks++;
        if (READ_ERR !== 1'b1 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL nopattern_read: got err=%b busy=%b expected 1 0", READ_ERR, BUSY);
        end
        EN_TEST_PATTERN = 1'b0;
`endif
    endtask

    initial begin
        @(negedge CLK40);
        test_reset();
        test_single_word();
        test_freeze();
        test_full_lost();
        test_read_err();
        test_reset_mid_shift();
        test_pattern();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
